// File: rtl/utopia_pkg.sv
// Shared Utopia/ATM definitions: cell layout, HEC constants,
// receive FSM states and words-per-cell helper.
package utopia_pkg;

  localparam int CELL_BYTES = 53;
  localparam int CELL_BITS  = CELL_BYTES * 8;

  localparam logic [7:0] HEC_POLY  = 8'h07;
  localparam logic [7:0] HEC_COSET = 8'h55;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SELECT,
    S_WAIT_SOC,
    S_RECV,
    S_HOLD
  } rx_state_e;

  typedef struct packed {
    logic [3:0]       GFC;
    logic [7:0]       VPI;
    logic [15:0]      VCI;
    logic [2:0]       PT;
    logic             CLP;
    logic [7:0]       HEC;
    logic [0:47][7:0] Payload;
  } UNI_t;

  typedef union packed {
    UNI_t                 uni;
    logic [CELL_BITS-1:0] raw;
  } ATMCellType;

  // 16-bit bus carries a 54-byte cell (UDF pad) in 27 words
  function automatic int words_per_cell(input int w);
    return (w == 16) ? (CELL_BYTES / 2 + 1) : CELL_BYTES;
  endfunction

endpackage

// File: rtl/utopia_rx_mphy_if.sv
// Cell hand-off from the Utopia receive master to the core.
// master: ATMcell/cell_phy/valid/hec_err out, ready in.
interface utopia_rx_mphy_if #(
  parameter int PW = 2
);

  logic [utopia_pkg::CELL_BITS-1:0] ATMcell;
  logic [PW-1:0]                    cell_phy;
  logic                             valid;
  logic                             ready;
  logic                             hec_err;

  modport master (
    output ATMcell, cell_phy, valid, hec_err,
    input  ready
  );

  modport slave (
    input  ATMcell, cell_phy, valid, hec_err,
    output ready
  );

endinterface

// File: rtl/utopia_hec.sv
// Combinational ATM header HEC: CRC-8 (x^8+x^2+x+1) of a
// 32-bit header, coset applied. i_hdr in, o_hec out.
module utopia_hec
  import utopia_pkg::*;
(
  input  logic [31:0] i_hdr,
  output logic [7:0]  o_hec
);

  logic [7:0] w_crc;

  always_comb begin
    w_crc = 8'h00;
    for (int i = 31; i >= 0; i--) begin
      if (w_crc[7] ^ i_hdr[i])
        w_crc = {w_crc[6:0], 1'b0} ^ HEC_POLY;
      else
        w_crc = {w_crc[6:0], 1'b0};
    end
  end

  assign o_hec = w_crc ^ HEC_COSET;

endmodule

// File: rtl/utopia_rx_mphy.sv
// Multi-PHY Utopia L2 receive master: round-robin PHY polling,
// cell capture, HEC check, cell hand-off and statistics.
// Ports: clk_in/reset; clav/data/soc in, en/phy_sel out (PHY
// side); cell_if (core side); saturating *_cnt statistics.
module utopia_rx_mphy
  import utopia_pkg::*;
#(
  parameter int NumPhy        = 4,
  parameter int IfWidth       = 8,
  parameter int TimeoutCycles = 64,
  parameter int CntWidth      = 16,
  localparam int PW = (NumPhy > 1) ? $clog2(NumPhy) : 1
) (
  input  logic                clk_in,
  input  logic                reset,
  input  logic [NumPhy-1:0]   clav,
  input  logic [IfWidth-1:0]  data,
  input  logic                soc,
  output logic                en,
  output logic [PW-1:0]       phy_sel,
  utopia_rx_mphy_if.master    cell_if,
  output logic [CntWidth-1:0] cell_cnt,
  output logic [CntWidth-1:0] hec_cnt,
  output logic [CntWidth-1:0] short_cnt,
  output logic [CntWidth-1:0] tmo_cnt
);

  localparam int WPC = words_per_cell(IfWidth);
  localparam int WW  = $clog2(TimeoutCycles) + 1;
  localparam logic [WW-1:0] WAIT_LAST =
    WW'(TimeoutCycles - 1);
  localparam logic [5:0] LAST_WORD = 6'(WPC - 1);

  rx_state_e     r_state, w_state;
  logic          r_en, w_en;
  logic [PW-1:0] r_sel, w_sel;
  logic [PW-1:0] r_rr, w_rr;
  logic [PW-1:0] r_cell_phy, w_cell_phy;
  logic [WW-1:0] r_wait, w_wait;
  logic [5:0]    r_widx, w_widx;
  ATMCellType    r_buf;

  logic [CntWidth-1:0] r_cell_cnt, r_hec_cnt;
  logic [CntWidth-1:0] r_short_cnt, r_tmo_cnt;

  logic          w_shift, w_half;
  logic          w_inc_cell, w_inc_hec;
  logic          w_inc_short, w_inc_tmo;
  logic          w_any;
  logic [PW-1:0] w_pick;
  logic [7:0]    w_hec;
  logic          w_hec_bad;
  logic [7:0]    w_hi, w_lo;

  // first requesting PHY strictly after the pointer, wrapping
  always_comb begin
    int idx;
    w_any  = 1'b0;
    w_pick = r_rr;
    idx    = 0;
    for (int k = NumPhy; k >= 1; k--) begin
      idx = int'(r_rr) + k;
      if (idx >= NumPhy) idx = idx - NumPhy;
      if ((clav & (NumPhy'(1) << idx)) != '0) begin
        w_any  = 1'b1;
        w_pick = PW'(idx);
      end
    end
  end

  utopia_hec u_hec (
    .i_hdr (r_buf.raw[CELL_BITS-1 -: 32]),
    .o_hec (w_hec)
  );

  assign w_hec_bad = (w_hec != r_buf.uni.HEC);

  always_comb begin
    w_state     = r_state;
    w_en        = r_en;
    w_sel       = r_sel;
    w_rr        = r_rr;
    w_cell_phy  = r_cell_phy;
    w_wait      = r_wait;
    w_widx      = r_widx;
    w_shift     = 1'b0;
    w_inc_cell  = 1'b0;
    w_inc_hec   = 1'b0;
    w_inc_short = 1'b0;
    w_inc_tmo   = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (w_any) begin
          w_sel   = w_pick;
          w_en    = 1'b0;
          w_state = S_SELECT;
        end
      end
      S_SELECT: begin
        w_wait  = '0;
        w_state = S_WAIT_SOC;
      end
      S_WAIT_SOC: begin
        if (soc) begin
          w_shift = 1'b1;
          w_widx  = 6'd1;
          w_state = S_RECV;
        end else if (r_wait == WAIT_LAST) begin
          w_en      = 1'b1;
          w_inc_tmo = 1'b1;
          w_rr      = r_sel;
          w_state   = S_IDLE;
        end else begin
          w_wait = r_wait + WW'(1);
        end
      end
      S_RECV: begin
        w_shift = 1'b1;
        if (soc) begin
          // resync: this word becomes word 0 of a new cell
          w_inc_short = 1'b1;
          w_widx      = 6'd1;
        end else if (r_widx == LAST_WORD) begin
          w_en       = 1'b1;
          w_cell_phy = r_sel;
          w_state    = S_HOLD;
        end else begin
          w_widx = r_widx + 6'd1;
        end
      end
      S_HOLD: begin
        if (cell_if.ready) begin
          w_inc_cell = 1'b1;
          w_inc_hec  = w_hec_bad;
          w_rr       = r_cell_phy;
          w_state    = S_IDLE;
        end
      end
      default: w_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_en       <= 1'b1;
      r_sel      <= '0;
      r_rr       <= '0;
      r_cell_phy <= '0;
      r_wait     <= '0;
      r_widx     <= '0;
    end else begin
      r_state    <= w_state;
      r_en       <= w_en;
      r_sel      <= w_sel;
      r_rr       <= w_rr;
      r_cell_phy <= w_cell_phy;
      r_wait     <= w_wait;
      r_widx     <= w_widx;
    end
  end

  if (IfWidth == 16) begin : g_w16
    assign w_hi = data[15:8];
    assign w_lo = data[7:0];
  end else begin : g_w8
    assign w_hi = data[7:0];
    assign w_lo = 8'h00;
  end

  // word 2 of a 16-bit cell keeps only its high byte (UDF drop)
  assign w_half = (IfWidth != 16) ||
                  (r_state == S_RECV && !soc &&
                   r_widx == 6'd2);

  // exactly CELL_BITS are shifted in after the last word 0,
  // so a discarded partial cell is fully flushed out
  always_ff @(posedge clk_in) begin
    if (reset) begin
      r_buf <= '0;
    end else if (w_shift) begin
      if (w_half)
        r_buf.raw <= {r_buf.raw[CELL_BITS-9:0], w_hi};
      else
        r_buf.raw <= {r_buf.raw[CELL_BITS-17:0], w_hi, w_lo};
    end
  end

  function automatic logic [CntWidth-1:0] sat_inc(
    input logic [CntWidth-1:0] v,
    input logic                inc
  );
    if (inc && !(&v)) return v + CntWidth'(1);
    return v;
  endfunction

  always_ff @(posedge clk_in) begin
    if (reset) begin
      r_cell_cnt  <= '0;
      r_hec_cnt   <= '0;
      r_short_cnt <= '0;
      r_tmo_cnt   <= '0;
    end else begin
      r_cell_cnt  <= sat_inc(r_cell_cnt, w_inc_cell);
      r_hec_cnt   <= sat_inc(r_hec_cnt, w_inc_hec);
      r_short_cnt <= sat_inc(r_short_cnt, w_inc_short);
      r_tmo_cnt   <= sat_inc(r_tmo_cnt, w_inc_tmo);
    end
  end

  assign en               = r_en;
  assign phy_sel          = r_sel;
  assign cell_if.ATMcell  = r_buf.raw;
  assign cell_if.cell_phy = r_cell_phy;
  assign cell_if.valid    = (r_state == S_HOLD);
  assign cell_if.hec_err  = (r_state == S_HOLD) && w_hec_bad;

  assign cell_cnt  = r_cell_cnt;
  assign hec_cnt   = r_hec_cnt;
  assign short_cnt = r_short_cnt;
  assign tmo_cnt   = r_tmo_cnt;

endmodule

// File: tb/tb_utopia_rx_mphy.sv
// Bench for utopia_rx_mphy: random cells on an 8-bit and a
// 16-bit instance checked against a cell-level model.
module tb_utopia_rx_mphy;
  import utopia_pkg::*;

  logic clk;
  logic rst;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [3:0]  clav8;
  logic [7:0]  data8;
  logic        soc8, en8;
  logic [1:0]  sel8;
  logic [15:0] cc8, hc8, sc8, tc8;
  utopia_rx_mphy_if #(.PW(2)) if8();

  utopia_rx_mphy #(
    .NumPhy(4), .IfWidth(8),
    .TimeoutCycles(64), .CntWidth(16)
  ) dut8 (
    .clk_in(clk), .reset(rst), .clav(clav8),
    .data(data8), .soc(soc8), .en(en8),
    .phy_sel(sel8), .cell_if(if8.master),
    .cell_cnt(cc8), .hec_cnt(hc8),
    .short_cnt(sc8), .tmo_cnt(tc8)
  );

  logic [3:0]  clav16;
  logic [15:0] data16;
  logic        soc16, en16;
  logic [1:0]  sel16;
  logic [15:0] cc16, hc16, sc16, tc16;
  utopia_rx_mphy_if #(.PW(2)) if16();

  utopia_rx_mphy #(
    .NumPhy(4), .IfWidth(16),
    .TimeoutCycles(64), .CntWidth(16)
  ) dut16 (
    .clk_in(clk), .reset(rst), .clav(clav16),
    .data(data16), .soc(soc16), .en(en16),
    .phy_sel(sel16), .cell_if(if16.master),
    .cell_cnt(cc16), .hec_cnt(hc16),
    .short_cnt(sc16), .tmo_cnt(tc16)
  );

  int errors = 0;
  int checks = 0;

  // model state
  int rr8 = 0;
  int n_cell8 = 0;
  int n_hec8 = 0;

  logic [7:0]   tx [0:52];
  logic [7:0]   s16 [0:53];
  bit           o_ok;
  logic [1:0]   o_sel, o_phy;
  logic         o_ve, o_v, o_hec;
  logic [423:0] o_cell;

  // HEC = remainder of header*x^8 mod x^8+x^2+x+1, coset 0x55
  function automatic logic [7:0] ref_hec(input logic [31:0] h);
    logic [39:0] r;
    r = {h, 8'h00};
    for (int i = 39; i >= 8; i--)
      if (r[i]) r[i -: 9] = r[i -: 9] ^ 9'h107;
    return r[7:0] ^ 8'h55;
  endfunction

  function automatic int rr_next(input int p, input logic [3:0] cv);
    int j;
    for (int k = 1; k <= 4; k++) begin
      j = (p + k) % 4;
      if (cv[j[1:0]]) return j;
    end
    return -1;
  endfunction

  function automatic logic [423:0] pack_tx();
    logic [423:0] r;
    for (int i = 0; i < 53; i++) r[423 - 8*i -: 8] = tx[i];
    return r;
  endfunction

  task automatic make_cell(input bit bad);
    for (int i = 0; i < 53; i++) tx[i] = 8'($urandom);
    tx[4] = ref_hec({tx[0], tx[1], tx[2], tx[3]});
    if (bad) tx[4] = tx[4] ^ 8'($urandom_range(1, 255));
  endtask

  task automatic wait_en8(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (en8 === 1'b0) begin ok = 1'b1; break; end
    end
  endtask

  task automatic drive8();
    for (int i = 0; i < 53; i++) begin
      @(negedge clk);
      data8 = tx[i];
      soc8  = (i == 0);
    end
  endtask

  task automatic observe8();
    o_ve = if8.valid;
    @(negedge clk);
    o_v    = if8.valid;
    o_cell = if8.ATMcell;
    o_phy  = if8.cell_phy;
    o_hec  = if8.hec_err;
  endtask

  task automatic run8(input bit drop);
    wait_en8(o_ok);
    o_sel = sel8;
    if (drop) clav8 = 4'b0000;
    o_v = 1'b0;
    if (o_ok) begin
      drive8();
      observe8();
    end
  endtask

  task automatic accept8();
    @(negedge clk);
    if8.ready = 1'b1;
    @(negedge clk);
    if8.ready = 1'b0;
  endtask

  task automatic test_reset();
    checks++; if (en8 !== 1'b1) begin errors++;
      $display("FAIL rst_en: got %b want 1", en8); end
    checks++; if (sel8 !== 2'd0) begin errors++;
      $display("FAIL rst_sel: got %0d want 0", sel8); end
    checks++; if (if8.valid !== 1'b0) begin errors++;
      $display("FAIL rst_valid: got %b want 0", if8.valid); end
    checks++; if (if8.hec_err !== 1'b0) begin errors++;
      $display("FAIL rst_hec: got %b want 0", if8.hec_err); end
    checks++; if (if8.ATMcell !== '0) begin errors++;
      $display("FAIL rst_cell: got %h want 0", if8.ATMcell); end
    checks++; if (if8.cell_phy !== 2'd0) begin errors++;
      $display("FAIL rst_phy: got %0d want 0", if8.cell_phy); end
    checks++;
    if ({cc8, hc8, sc8, tc8} !== 64'd0) begin errors++;
      $display("FAIL rst_cnt: got %h want 0", {cc8, hc8, sc8, tc8});
    end
    checks++; if (en16 !== 1'b1) begin errors++;
      $display("FAIL rst_en16: got %b want 1", en16); end
  endtask

  task automatic test_single_cell();
    int e;
    for (int i = 0; i < 5; i++) tx[i] = 8'h00;
    tx[4] = 8'h55;
    for (int i = 0; i < 48; i++) tx[5 + i] = 8'(i);
    e = rr_next(rr8, 4'b0001);
    clav8 = 4'b0001;
    run8(1'b1);
    checks++; if (!o_ok) begin errors++;
      $display("FAIL single_en: got en=1 want en=0 in bound"); end
    checks++; if (o_sel !== 2'(e)) begin errors++;
      $display("FAIL single_sel: got %0d want %0d", o_sel, e); end
    checks++; if (o_ve !== 1'b0 || o_v !== 1'b1) begin errors++;
      $display("FAIL single_lat: got %b%b want 01", o_ve, o_v); end
    checks++; if (o_hec !== 1'b0) begin errors++;
      $display("FAIL single_hec: got %b want 0", o_hec); end
    checks++; if (o_phy !== 2'd0) begin errors++;
      $display("FAIL single_phy: got %0d want 0", o_phy); end
    checks++; if (o_cell !== pack_tx()) begin errors++;
      $display("FAIL single_cell: got %h want %h", o_cell, pack_tx());
    end
    accept8();
    rr8 = e; n_cell8++;
    checks++;
    if (cc8 !== 16'(n_cell8) || if8.valid !== 1'b0) begin
      errors++;
      $display("FAIL single_cnt: got %0d/%b want %0d/0",
               cc8, if8.valid, n_cell8);
    end
  endtask

  task automatic test_hec();
    logic [7:0] hv [0:1];
    hv[0] = 8'h55;
    hv[1] = 8'h52;
    for (int c = 0; c < 2; c++) begin
      make_cell(1'b0);
      tx[0] = 8'h00; tx[1] = 8'h00; tx[2] = 8'h00;
      tx[3] = 8'h01; tx[4] = hv[c];
      clav8 = 4'b0001;
      run8(1'b1);
      checks++;
      if (o_v !== 1'b1 || o_hec !== (c == 0)) begin errors++;
        $display("FAIL hec_flag%0d: got v=%b h=%b want v=1 h=%b",
                 c, o_v, o_hec, c == 0);
      end
      accept8();
      rr8 = 0; n_cell8++;
      if (c == 0) n_hec8++;
      checks++; if (hc8 !== 16'(n_hec8)) begin errors++;
        $display("FAIL hec_cnt%0d: got %0d want %0d", c, hc8, n_hec8);
      end
    end
  endtask

  task automatic test_round_robin();
    int e;
    bit bad;
    clav8 = 4'b1111;
    if8.ready = 1'b1;
    for (int c = 0; c < 5; c++) begin
      e = rr_next(rr8, 4'b1111);
      bad = 1'($urandom_range(0, 1));
      make_cell(bad);
      run8(1'b0);
      checks++;
      if (!o_ok || o_sel !== 2'(e) || o_phy !== 2'(e)) begin
        errors++;
        $display("FAIL rr_order%0d: got sel=%0d phy=%0d want %0d",
                 c, o_sel, o_phy, e);
      end
      checks++;
      if (o_v !== 1'b1 || o_cell !== pack_tx()) begin errors++;
        $display("FAIL rr_cell%0d: got %h want %h",
                 c, o_cell, pack_tx());
      end
      checks++; if (o_hec !== bad) begin errors++;
        $display("FAIL rr_hec%0d: got %b want %b", c, o_hec, bad);
      end
      rr8 = e; n_cell8++;
      if (bad) n_hec8++;
    end
    clav8 = 4'b0000;
    @(negedge clk);
    if8.ready = 1'b0;
    @(negedge clk);
    checks++;
    if (cc8 !== 16'(n_cell8) || hc8 !== 16'(n_hec8)) begin
      errors++;
      $display("FAIL rr_cnt: got %0d/%0d want %0d/%0d",
               cc8, hc8, n_cell8, n_hec8);
    end
  endtask

  task automatic test_backpressure_timeout();
    int e, nx, n, bad;
    clav8 = 4'b1111;
    if8.ready = 1'b0;
    e = rr_next(rr8, 4'b1111);
    make_cell(1'b0);
    run8(1'b0);
    checks++;
    if (!o_ok || o_v !== 1'b1 || o_sel !== 2'(e)) begin
      errors++;
      $display("FAIL bp_cell: got v=%b sel=%0d want v=1 sel=%0d",
               o_v, o_sel, e);
    end
    bad = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      data8 = 8'($urandom);
      soc8  = 1'($urandom);
      if (if8.ATMcell !== o_cell || en8 !== 1'b1 ||
          if8.valid !== 1'b1 || cc8 !== 16'(n_cell8))
        bad++;
    end
    soc8 = 1'b0;
    checks++; if (bad != 0) begin errors++;
      $display("FAIL bp_hold: got %0d bad cycles want 0", bad);
    end
    rr8 = e; n_cell8++;
    nx = rr_next(rr8, 4'b1111);
    if8.ready = 1'b1;
    n = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      n++;
      if8.ready = 1'b0;
      if (en8 === 1'b0) break;
    end
    clav8 = 4'b0000;
    checks++;
    if (en8 !== 1'b0 || n > 2 || sel8 !== 2'(nx)) begin
      errors++;
      $display("FAIL bp_next: got n=%0d sel=%0d want n<=2 sel=%0d",
               n, sel8, nx);
    end
    n = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      n++;
      if (en8 === 1'b1) break;
    end
    checks++; if (n != 65) begin errors++;
      $display("FAIL tmo_len: got %0d cycles want 65", n);
    end
    checks++;
    if (tc8 !== 16'd1 || if8.valid !== 1'b0) begin errors++;
      $display("FAIL tmo_cnt: got %0d v=%b want 1 v=0",
               tc8, if8.valid);
    end
    rr8 = nx;
  endtask

  task automatic test_resync();
    int p;
    bit bad;
    p = $urandom_range(0, 3);
    clav8 = 4'b0001 << p;
    wait_en8(o_ok);
    o_sel = sel8;
    clav8 = 4'b0000;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      data8 = 8'($urandom);
      soc8  = (i == 0);
    end
    bad = 1'($urandom_range(0, 1));
    make_cell(bad);
    drive8();
    observe8();
    checks++;
    if (!o_ok || o_sel !== 2'(p) || o_phy !== 2'(p)) begin
      errors++;
      $display("FAIL resync_phy: got %0d/%0d want %0d",
               o_sel, o_phy, p);
    end
    checks++;
    if (o_ve !== 1'b0 || o_v !== 1'b1 ||
        o_cell !== pack_tx() || o_hec !== bad) begin
      errors++;
      $display("FAIL resync_cell: got %h want %h",
               o_cell, pack_tx());
    end
    checks++; if (sc8 !== 16'd1) begin errors++;
      $display("FAIL resync_short: got %0d want 1", sc8);
    end
    accept8();
    n_cell8++;
    if (bad) n_hec8++;
    checks++;
    if (cc8 !== 16'(n_cell8) || hc8 !== 16'(n_hec8)) begin
      errors++;
      $display("FAIL resync_cnt: got %0d/%0d want %0d/%0d",
               cc8, hc8, n_cell8, n_hec8);
    end
  endtask

  task automatic wait_en16(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (en16 === 1'b0) begin ok = 1'b1; break; end
    end
  endtask

  task automatic test_16bit();
    bit ok, bad;
    logic ve;
    bad = 1'($urandom_range(0, 1));
    make_cell(bad);
    for (int i = 0; i < 54; i++)
      s16[i] = (i < 5) ? tx[i] :
               (i == 5) ? 8'($urandom) : tx[i - 1];
    clav16 = 4'b0001;
    wait_en16(ok);
    clav16 = 4'b0000;
    checks++; if (!ok || sel16 !== 2'd0) begin errors++;
      $display("FAIL w16_sel: got %0d want 0", sel16); end
    for (int w = 0; w < 27; w++) begin
      @(negedge clk);
      data16 = {s16[2*w], s16[2*w + 1]};
      soc16  = (w == 0);
    end
    ve = if16.valid;
    @(negedge clk);
    checks++; if (ve !== 1'b0 || if16.valid !== 1'b1) begin
      errors++;
      $display("FAIL w16_lat: got %b%b want 01", ve, if16.valid);
    end
    checks++; if (if16.ATMcell !== pack_tx()) begin errors++;
      $display("FAIL w16_cell: got %h want %h",
               if16.ATMcell, pack_tx());
    end
    checks++;
    if (if16.hec_err !== bad || if16.cell_phy !== 2'd0) begin
      errors++;
      $display("FAIL w16_hec: got %b/%0d want %b/0",
               if16.hec_err, if16.cell_phy, bad);
    end
    @(negedge clk);
    if16.ready = 1'b1;
    @(negedge clk);
    if16.ready = 1'b0;
    checks++; if (cc16 !== 16'd1 || if16.valid !== 1'b0) begin
      errors++;
      $display("FAIL w16_cnt: got %0d want 1", cc16);
    end
  endtask

  task automatic test_reset_midcell();
    bit ok;
    int bad;
    make_cell(1'b0);
    clav16 = 4'b0001;
    wait_en16(ok);
    clav16 = 4'b0000;
    for (int w = 0; w < 11; w++) begin
      @(negedge clk);
      data16 = 16'($urandom);
      soc16  = (w == 0);
      if (w == 10) rst = 1'b1;
    end
    @(negedge clk);
    rst = 1'b0;
    soc16 = 1'b0;
    checks++;
    if (!ok || if16.valid !== 1'b0 || en16 !== 1'b1) begin
      errors++;
      $display("FAIL mid_rst: got v=%b en=%b want v=0 en=1",
               if16.valid, en16);
    end
    checks++;
    if ({cc16, hc16, sc16, tc16} !== 64'd0 || cc8 !== 16'd0) begin
      errors++;
      $display("FAIL mid_cnt: got %h/%0d want 0",
               {cc16, hc16, sc16, tc16}, cc8);
    end
    checks++;
    if (if16.ATMcell !== '0 || sel16 !== 2'd0) begin errors++;
      $display("FAIL mid_state: got %h want 0", if16.ATMcell);
    end
    bad = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      data16 = 16'($urandom);
      if (if16.valid !== 1'b0 || en16 !== 1'b1) bad++;
    end
    checks++; if (bad != 0) begin errors++;
      $display("FAIL mid_idle: got %0d bad cycles want 0", bad);
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    clav8 = '0; data8 = '0; soc8 = 1'b0;
    clav16 = '0; data16 = '0; soc16 = 1'b0;
    if8.ready = 1'b0;
    if16.ready = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    test_reset();
    test_single_cell();
    test_hec();
    test_round_robin();
    test_backpressure_timeout();
    test_resync();
    test_16bit();
    test_reset_midcell();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
